// File: rtl/vid_pkg.sv
// Shared constants for the video pattern transmitter: pattern codes, LFSR seed/taps, raster totals.
package vid_pkg;

  typedef enum logic [2:0] {
    PAT_SOLID = 3'd0,
    PAT_RAMP  = 3'd1,
    PAT_CHECK = 3'd2,
    PAT_LINE  = 3'd3,
    PAT_LFSR  = 3'd4
  } pat_e;

  localparam int COORD_W = 16;

  localparam logic [15:0] LFSR_SEED = 16'hACE1;
  // Right-shift Fibonacci form of x^16+x^14+x^13+x^11+1: feedback from bits 0,2,3,5.
  localparam logic [15:0] LFSR_TAPS = 16'h002D;

  function automatic int unsigned vid_total(input int unsigned active, input int unsigned fp,
                                            input int unsigned sync, input int unsigned bp);
    return active + fp + sync + bp;
  endfunction

  function automatic logic [15:0] lfsr_next(input logic [15:0] s);
    return {^(s & LFSR_TAPS), s[15:1]};
  endfunction

endpackage

// File: rtl/vid_timing.sv
// Raster counters and region decode; all outputs are combinational from counter state and en_i.
module vid_timing
  import vid_pkg::*;
#(
  parameter int H_ACTIVE = 1920,
  parameter int H_FP     = 88,
  parameter int H_SYNC   = 44,
  parameter int H_BP     = 148,
  parameter int V_ACTIVE = 1080,
  parameter int V_FP     = 4,
  parameter int V_SYNC   = 5,
  parameter int V_BP     = 36
) (
  input  logic               clk_i,
  input  logic               rst_ni,
  input  logic               en_i,
  output logic               de,
  output logic               hs,
  output logic               vs,
  output logic               frame_start,
  output logic [COORD_W-1:0] x,
  output logic [COORD_W-1:0] y
);

  localparam int H_TOTAL = int'(vid_total(H_ACTIVE, H_FP, H_SYNC, H_BP));
  localparam int V_TOTAL = int'(vid_total(V_ACTIVE, V_FP, V_SYNC, V_BP));
  localparam int HW = $clog2(H_TOTAL);
  localparam int VW = $clog2(V_TOTAL);

  localparam logic [HW-1:0] H_LAST = HW'(H_TOTAL - 1);
  localparam logic [VW-1:0] V_LAST = VW'(V_TOTAL - 1);

  logic [HW-1:0] h;
  logic [VW-1:0] v;
  logic [31:0]   hx;
  logic [31:0]   vx;

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      h <= '0;
      v <= '0;
    end else if (!en_i) begin
      h <= '0;
      v <= '0;
    end else if (h == H_LAST) begin
      h <= '0;
      v <= (v == V_LAST) ? '0 : v + VW'(1);
    end else begin
      h <= h + HW'(1);
    end
  end

  assign hx = 32'(h);
  assign vx = 32'(v);

  // Decode is gated by en_i so a dropped enable idles the outputs on the very next edge.
  assign de = en_i && (hx < H_ACTIVE) && (vx < V_ACTIVE);
  assign hs = en_i && (hx >= H_ACTIVE + H_FP) && (hx < H_ACTIVE + H_FP + H_SYNC);
  assign vs = en_i && (vx >= V_ACTIVE + V_FP) && (vx < V_ACTIVE + V_FP + V_SYNC);
  assign frame_start = en_i && (h == '0) && (v == '0);

  assign x = COORD_W'(h);
  assign y = COORD_W'(v);

endmodule

// File: rtl/vid_pattern_tx.sv
// Video pattern transmitter: raster timing plus registered pattern pixels.
// Optional LFSR pattern (code 4) is built only when VID_PATTERN_LFSR_EN is defined.
module vid_pattern_tx
  import vid_pkg::*;
#(
  parameter int H_ACTIVE = 1920,
  parameter int H_FP     = 88,
  parameter int H_SYNC   = 44,
  parameter int H_BP     = 148,
  parameter int V_ACTIVE = 1080,
  parameter int V_FP     = 4,
  parameter int V_SYNC   = 5,
  parameter int V_BP     = 36,
  parameter bit HS_POL   = 1'b1,
  parameter int BLK_LOG2 = 4
) (
  input  logic       clk_i,
  input  logic       rst_ni,
  input  logic       en_i,
  input  logic [2:0] pat_i,
  input  logic [7:0] level_i,
  output logic       hs_o,
  output logic       vs_o,
  output logic       de_o,
  output logic [7:0] wd_o,
  output logic       frame_o
);

  logic               t_de;
  logic               t_hs;
  logic               t_vs;
  logic               t_frame;
  logic [COORD_W-1:0] x;
  logic [COORD_W-1:0] y;

  logic [2:0] pat_q;
  logic [2:0] pat_cur;
  logic [7:0] lvl_q;
  logic [7:0] lvl_cur;
  logic [7:0] wd_d;
  logic       unused_coord;

  vid_timing #(
    .H_ACTIVE(H_ACTIVE), .H_FP(H_FP), .H_SYNC(H_SYNC), .H_BP(H_BP),
    .V_ACTIVE(V_ACTIVE), .V_FP(V_FP), .V_SYNC(V_SYNC), .V_BP(V_BP)
  ) u_timing (
    .clk_i       (clk_i),
    .rst_ni      (rst_ni),
    .en_i        (en_i),
    .de          (t_de),
    .hs          (t_hs),
    .vs          (t_vs),
    .frame_start (t_frame),
    .x           (x),
    .y           (y)
  );

  // The first pixel of a frame must already use the newly sampled selection.
  assign pat_cur = t_frame ? pat_i   : pat_q;
  assign lvl_cur = t_frame ? level_i : lvl_q;
  assign unused_coord = ^{x, y};

`ifdef VID_PATTERN_LFSR_EN
  logic [15:0] lfsr_q;
  logic [15:0] lfsr_cur;

  assign lfsr_cur = t_frame ? LFSR_SEED : lfsr_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      lfsr_q <= LFSR_SEED;
    end else if (t_de) begin
      lfsr_q <= lfsr_next(lfsr_cur);
    end
  end
`endif

  // NOTE: wd_d gets a default before the case so no path leaves it unassigned (no latch).
  always_comb begin
    wd_d = 8'h00;
    if (t_de) begin
      case (pat_cur)
        PAT_SOLID: wd_d = lvl_cur;
        PAT_RAMP:  wd_d = x[7:0];
        PAT_CHECK: wd_d = (x[BLK_LOG2] ^ y[BLK_LOG2]) ? 8'hFF : 8'h00;
        PAT_LINE:  wd_d = y[0] ? ~lvl_cur : lvl_cur;
`ifdef VID_PATTERN_LFSR_EN
        PAT_LFSR:  wd_d = lfsr_cur[7:0];
`endif
        default:   wd_d = 8'h00;
      endcase
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      hs_o    <= ~HS_POL;
      vs_o    <= ~HS_POL;
      de_o    <= 1'b0;
      wd_o    <= 8'h00;
      frame_o <= 1'b0;
      pat_q   <= 3'd0;
      lvl_q   <= 8'h00;
    end else begin
      hs_o    <= t_hs ? HS_POL : ~HS_POL;
      vs_o    <= t_vs ? HS_POL : ~HS_POL;
      de_o    <= t_de;
      wd_o    <= wd_d;
      frame_o <= t_frame;
      if (t_frame) begin
        pat_q <= pat_i;
        lvl_q <= level_i;
      end
    end
  end

endmodule

// File: tb/tb_vid_pattern_tx.sv
// Self-checking bench for vid_pattern_tx on a 14x7 raster with a frame-position reference model.
module tb_vid_pattern_tx;

  localparam int HA = 8, HF = 2, HSY = 2, HB = 2;
  localparam int VA = 4, VF = 1, VSY = 1, VB = 1;
  localparam int BLK = 1;
  localparam int HT = HA + HF + HSY + HB;
  localparam int VT = VA + VF + VSY + VB;
  localparam int FT = HT * VT;
  localparam bit POL = 1'b1;
  localparam logic [11:0] IDLE = {~POL, ~POL, 1'b0, 1'b0, 8'h00};

  logic       clk_i   = 1'b0;
  logic       rst_ni  = 1'b0;
  logic       en_i    = 1'b0;
  logic [2:0] pat_i   = 3'd0;
  logic [7:0] level_i = 8'h00;
  logic       hs_o, vs_o, de_o, frame_o;
  logic [7:0] wd_o;

  int tests = 0;
  int fails = 0;
  bit chk_en = 1'b0;

  logic [7:0] lfsr_tab [0:HA*VA-1];

  always #5 clk_i = ~clk_i;

  vid_pattern_tx #(
    .H_ACTIVE(HA), .H_FP(HF), .H_SYNC(HSY), .H_BP(HB),
    .V_ACTIVE(VA), .V_FP(VF), .V_SYNC(VSY), .V_BP(VB),
    .HS_POL(POL), .BLK_LOG2(BLK)
  ) dut (
    .clk_i   (clk_i),
    .rst_ni  (rst_ni),
    .en_i    (en_i),
    .pat_i   (pat_i),
    .level_i (level_i),
    .hs_o    (hs_o),
    .vs_o    (vs_o),
    .de_o    (de_o),
    .wd_o    (wd_o),
    .frame_o (frame_o)
  );

  wire [11:0] outs = {hs_o, vs_o, de_o, frame_o, wd_o};

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h, want %h", name, act, exp);
    end
  endtask

  function automatic logic [7:0] lfsr_exp(input int k);
`ifdef VID_PATTERN_LFSR_EN
    return lfsr_tab[k];
`else
    return (k >= 0) ? 8'h00 : 8'h00;
`endif
  endfunction

  // Expected outputs for a given position inside the frame (0 .. FT-1).
  function automatic logic [11:0] model_out(input int pos, input logic [2:0] pat, input logic [7:0] lvl);
    int x, y;
    logic hs, vs, de;
    logic [7:0] wd;
    x  = pos % HT;
    y  = pos / HT;
    de = (x < HA) && (y < VA);
    hs = (x >= HA + HF) && (x < HA + HF + HSY);
    vs = (y >= VA + VF) && (y < VA + VF + VSY);
    wd = 8'h00;
    if (de) begin
      case (pat)
        3'd0: wd = lvl;
        3'd1: wd = 8'(x % 256);
        3'd2: wd = (((x / (1 << BLK)) + (y / (1 << BLK))) % 2 == 1) ? 8'hFF : 8'h00;
        3'd3: wd = (y % 2 == 1) ? ~lvl : lvl;
        3'd4: wd = lfsr_exp(y * HA + x);
        default: wd = 8'h00;
      endcase
    end
    return {hs ? POL : ~POL, vs ? POL : ~POL, de, (pos == 0), wd};
  endfunction

  int         m_pos;
  logic [2:0] m_pat;
  logic [7:0] m_lvl;
  logic [11:0] m_exp;

  always @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      m_pos <= 0;
      m_pat <= 3'd0;
      m_lvl <= 8'h00;
      m_exp <= IDLE;
    end else if (!en_i) begin
      m_pos <= 0;
      m_exp <= IDLE;
    end else begin
      m_exp <= model_out(m_pos, (m_pos == 0) ? pat_i : m_pat, (m_pos == 0) ? level_i : m_lvl);
      if (m_pos == 0) begin
        m_pat <= pat_i;
        m_lvl <= level_i;
      end
      m_pos <= (m_pos + 1) % FT;
    end
  end

  always @(negedge clk_i) begin
    if (chk_en) check("scoreboard", {4'h0, outs}, {4'h0, m_exp});
  end

  // Idle one cycle with new selections, then raise en_i; the next posedge is frame position 0.
  task automatic restart(input logic [2:0] p, input logic [7:0] l);
    @(negedge clk_i);
    en_i = 1'b0;
    pat_i = p;
    level_i = l;
    @(negedge clk_i);
    en_i = 1'b1;
  endtask

  typedef struct {
    logic [2:0] pat;
    logic [7:0] lvl;
    int         x;
    int         y;
    logic [7:0] wd;
  } vec_t;

  vec_t vecs[$];

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout, want completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [15:0] s;
    logic        fb;
    int de_n, hs_n, vs_n, fr_n, f_first, f_second;

    s = 16'hACE1;
    for (int i = 0; i < HA * VA; i++) begin
      lfsr_tab[i] = s[7:0];
      fb = s[0] ^ s[2] ^ s[3] ^ s[5];
      s = {fb, s[15:1]};
    end

    vecs.push_back('{3'd3, 8'h20, 0, 0, 8'h20});
    vecs.push_back('{3'd3, 8'h20, 7, 0, 8'h20});
    vecs.push_back('{3'd3, 8'h20, 0, 1, 8'hDF});
    vecs.push_back('{3'd3, 8'h20, 5, 1, 8'hDF});
    vecs.push_back('{3'd3, 8'h20, 3, 2, 8'h20});
    vecs.push_back('{3'd3, 8'h20, 9, 1, 8'h00});
    vecs.push_back('{3'd0, 8'h5A, 4, 3, 8'h5A});
    vecs.push_back('{3'd1, 8'h00, 0, 0, 8'h00});
    vecs.push_back('{3'd1, 8'h00, 7, 2, 8'h07});
    vecs.push_back('{3'd2, 8'h00, 1, 0, 8'h00});
    vecs.push_back('{3'd2, 8'h00, 2, 0, 8'hFF});
    vecs.push_back('{3'd2, 8'h00, 4, 0, 8'h00});
    vecs.push_back('{3'd2, 8'h00, 0, 2, 8'hFF});
    vecs.push_back('{3'd2, 8'h00, 2, 2, 8'h00});
    vecs.push_back('{3'd2, 8'h00, 3, 1, 8'hFF});
    vecs.push_back('{3'd5, 8'hFF, 1, 0, 8'h00});
    vecs.push_back('{3'd7, 8'hFF, 6, 3, 8'h00});
`ifdef VID_PATTERN_LFSR_EN
    vecs.push_back('{3'd4, 8'h00, 0, 0, 8'hE1});
    vecs.push_back('{3'd4, 8'h00, 1, 0, 8'h70});
`else
    vecs.push_back('{3'd4, 8'h00, 0, 0, 8'h00});
    vecs.push_back('{3'd4, 8'h00, 1, 0, 8'h00});
`endif

    // Reset state
    repeat (3) @(posedge clk_i);
    #1;
    check("reset", {4'h0, outs}, {4'h0, IDLE});
    @(negedge clk_i);
    rst_ni = 1'b1;
    chk_en = 1'b1;
    @(posedge clk_i);
    #1;
    check("idle_en_low", {4'h0, outs}, {4'h0, IDLE});

    // Timing over two frames
    restart(3'd0, 8'h11);
    de_n = 0; hs_n = 0; vs_n = 0; fr_n = 0; f_first = -1; f_second = -1;
    for (int c = 0; c < 2 * FT; c++) begin
      @(posedge clk_i);
      #1;
      if (de_o) de_n++;
      if (hs_o == POL) hs_n++;
      if (vs_o == POL) vs_n++;
      if (frame_o) begin
        fr_n++;
        if (f_first < 0) f_first = c;
        else if (f_second < 0) f_second = c;
      end
    end
    check("de_count", 16'(de_n), 16'(2 * HA * VA));
    check("hs_count", 16'(hs_n), 16'(2 * VT * HSY));
    check("vs_count", 16'(vs_n), 16'(2 * HT));
    check("frame_count", 16'(fr_n), 16'd2);
    check("frame_first", 16'(f_first), 16'd0);
    check("frame_period", 16'(f_second - f_first), 16'(FT));

    // Table-driven pattern vectors
    foreach (vecs[i]) begin
      restart(vecs[i].pat, vecs[i].lvl);
      repeat (vecs[i].y * HT + vecs[i].x + 1) @(posedge clk_i);
      #1;
      check($sformatf("vec%0d", i), {8'h00, wd_o}, {8'h00, vecs[i].wd});
    end

    // Mid-frame pattern change takes effect at the next frame only
    restart(3'd1, 8'h00);
    for (int c = 0; c <= FT + 30; c++) begin
      @(posedge clk_i);
      #1;
      if (c == 7)       check("latch_ramp7", {8'h00, wd_o}, 16'h0007);
      if (c == 20)      pat_i = 3'd2;
      if (c == 30)      check("latch_ramp_cur", {8'h00, wd_o}, 16'h0002);
      if (c == FT)      check("latch_frame", {15'h0, frame_o}, 16'h0001);
      if (c == FT + 2)  check("latch_chk_l0", {8'h00, wd_o}, 16'h00FF);
      if (c == FT + 28) check("latch_chk_l2x0", {8'h00, wd_o}, 16'h00FF);
      if (c == FT + 30) check("latch_chk_l2x2", {8'h00, wd_o}, 16'h0000);
    end

    // Enable dropped on frame pixel 20, then re-raised
    restart(3'd1, 8'h00);
    for (int c = 0; c <= 20; c++) begin
      @(posedge clk_i);
      #1;
    end
    check("en_pre", {15'h0, de_o}, 16'h0001);
    en_i = 1'b0;
    @(posedge clk_i);
    #1;
    check("en_drop", {4'h0, outs}, {4'h0, IDLE});
    en_i = 1'b1;
    @(posedge clk_i);
    #1;
    check("en_restart", {13'h0, frame_o, de_o, 1'b0}, 16'h0006);
    check("en_restart_wd", {8'h00, wd_o}, 16'h0000);
    @(posedge clk_i);
    #1;
    check("en_restart_x1", {7'h0, frame_o, wd_o}, 16'h0001);

    // Asynchronous reset between edges
    restart(3'd1, 8'h00);
    repeat (4) @(posedge clk_i);
    #1;
    check("rst_pre", {8'h00, wd_o}, 16'h0003);
    #2;
    rst_ni = 1'b0;
    #1;
    check("rst_async", {4'h0, outs}, {4'h0, IDLE});
    @(negedge clk_i);
    rst_ni = 1'b1;
    @(posedge clk_i);
    #1;
    check("rst_cold_frame", {4'h0, outs}, {4'h0, POL ? 1'b0 : 1'b1, POL ? 1'b0 : 1'b1, 1'b1, 1'b1, 8'h00});
    @(posedge clk_i);
    #1;
    check("rst_cold_x1", {7'h0, frame_o, wd_o}, 16'h0001);

    // LFSR words at the start of two consecutive frames
    restart(3'd4, 8'h00);
    for (int c = 0; c < FT + 4; c++) begin
      @(posedge clk_i);
      #1;
      if (c < 4) check($sformatf("lfsr_f1_%0d", c), {8'h00, wd_o}, {8'h00, lfsr_exp(c)});
      if (c >= FT) check($sformatf("lfsr_f2_%0d", c - FT), {8'h00, wd_o}, {8'h00, lfsr_exp(c - FT)});
    end

    // Randomized traffic against the scoreboard
    for (int i = 0; i < 3000; i++) begin
      @(negedge clk_i);
      if ($urandom_range(0, 299) == 0) en_i = 1'b0;
      else if (!en_i && $urandom_range(0, 2) == 0) en_i = 1'b1;
      if ($urandom_range(0, 24) == 0) pat_i = 3'($urandom_range(0, 7));
      if ($urandom_range(0, 24) == 0) level_i = 8'($urandom_range(0, 255));
    end

    @(negedge clk_i);
    chk_en = 1'b0;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
